// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline (optional perf counters: PIPE_HAZARD_CTRL_PERF_EN)
module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int LDUSE_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs1_addr,
  input  logic [4:0] id_rs2_addr,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd_addr,
  input  logic       redirect_valid,
  input  logic       me_req,
  input  logic       me_ready,
  output logic       pc_stall,
  output logic       if_id_stall,
  output logic       if_id_flush,
  output logic       id_ex_stall,
  output logic       id_ex_bubble,
  output logic       ex_me_stall,
  output logic       me_wb_bubble,
  output logic [1:0] state_o,
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  output logic [31:0] perf_stall_cyc,
  output logic [31:0] perf_flush_cnt,
`endif
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDUSE   = 2'd1,
    ST_MEMWAIT = 2'd2,
    ST_REDIR   = 2'd3
  } state_t;

  localparam logic [7:0] FLUSH_RELOAD = 8'(FLUSH_CYCLES - 1);
  localparam logic [7:0] LDUSE_RELOAD = 8'(LDUSE_CYCLES - 1);
  localparam logic [7:0] WAIT_LAST    = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_err_q, timeout_err_d;

  logic ldu, mw;
  logic stall_all, flush_front, ldu_bubble, redirect_acc;

  // Hazard detection; gated by reset so the controls read zero while held in reset
  always_comb begin
    ldu = rst_n & ex_mem_read & (ex_rd_addr != 5'd0) &
          ((id_use_rs1 & (id_rs1_addr == ex_rd_addr)) |
           (id_use_rs2 & (id_rs2_addr == ex_rd_addr)));
    mw  = rst_n & me_req & ~me_ready;
  end

  // Next-state, counter and control-class selection
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    timeout_err_d = timeout_err_q;
    stall_all     = 1'b0;
    flush_front   = 1'b0;
    ldu_bubble    = 1'b0;
    redirect_acc  = 1'b0;
    if (rst_n) begin
      if (state_q == ST_MEMWAIT) begin
        if (me_ready) begin
          state_d = ST_RUN;
          cnt_d   = 8'd0;
        end else begin
          // Still waiting: hold everything; the last permitted wait cycle aborts
          stall_all = 1'b1;
          cnt_d     = cnt_q + 8'd1;
          if (cnt_q >= WAIT_LAST) begin
            timeout_err_d = 1'b1;
            state_d       = ST_RUN;
            cnt_d         = 8'd0;
          end
        end
      end else if (mw) begin
        // Memory wait pre-empts any remaining flush/bubble count
        stall_all = 1'b1;
        state_d   = ST_MEMWAIT;
        cnt_d     = 8'd1;
      end else if (redirect_valid) begin
        flush_front  = 1'b1;
        redirect_acc = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_d = ST_REDIR;
          cnt_d   = FLUSH_RELOAD;
        end else begin
          state_d = ST_RUN;
          cnt_d   = 8'd0;
        end
      end else if (state_q == ST_REDIR) begin
        flush_front = 1'b1;
        cnt_d       = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) begin
          state_d = ST_RUN;
          cnt_d   = 8'd0;
        end
      end else if (state_q == ST_LDUSE) begin
        ldu_bubble = 1'b1;
        cnt_d      = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) begin
          state_d = ST_RUN;
          cnt_d   = 8'd0;
        end
      end else if (ldu) begin
        ldu_bubble = 1'b1;
        if (LDUSE_CYCLES > 1) begin
          state_d = ST_LDUSE;
          cnt_d   = LDUSE_RELOAD;
        end
      end
    end
  end

  // Map control classes onto the per-register stall/flush/bubble lines
  always_comb begin
    pc_stall     = stall_all | ldu_bubble;
    if_id_stall  = stall_all | ldu_bubble;
    if_id_flush  = flush_front;
    id_ex_stall  = stall_all;
    id_ex_bubble = flush_front | ldu_bubble;
    ex_me_stall  = stall_all;
    me_wb_bubble = stall_all;
    state_o      = state_q;
    timeout_err  = timeout_err_q;
  end

  // State, counter and sticky timeout flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      cnt_q         <= 8'd0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] perf_stall_cyc_q, perf_stall_cyc_d;
  logic [31:0] perf_flush_cnt_q, perf_flush_cnt_d;

  // Saturating event counters
  always_comb begin
    perf_stall_cyc_d = perf_stall_cyc_q;
    perf_flush_cnt_d = perf_flush_cnt_q;
    if (pc_stall && perf_stall_cyc_q != 32'hFFFF_FFFF)
      perf_stall_cyc_d = perf_stall_cyc_q + 32'd1;
    if (redirect_acc && perf_flush_cnt_q != 32'hFFFF_FFFF)
      perf_flush_cnt_d = perf_flush_cnt_q + 32'd1;
  end

  // Perf counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cyc_q <= 32'd0;
      perf_flush_cnt_q <= 32'd0;
    end else begin
      perf_stall_cyc_q <= perf_stall_cyc_d;
      perf_flush_cnt_q <= perf_flush_cnt_d;
    end
  end

  assign perf_stall_cyc = perf_stall_cyc_q;
  assign perf_flush_cnt = perf_flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic       id_use_rs1, id_use_rs2, ex_mem_read;
  logic       redirect_valid, me_req, me_ready;
  logic       pc_stall, if_id_stall, if_id_flush, id_ex_stall;
  logic       id_ex_bubble, ex_me_stall, me_wb_bubble, timeout_err;
  logic [1:0] state_o;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] perf_stall_cyc, perf_flush_cnt;
`endif

  int errors = 0;
  int checks = 0;

  // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble, ex_me_stall, me_wb_bubble}
  localparam logic [6:0] C_NONE  = 7'b0000000;
  localparam logic [6:0] C_STALL = 7'b1101011;
  localparam logic [6:0] C_LDU   = 7'b1100100;
  localparam logic [6:0] C_FLUSH = 7'b0010100;

  logic [6:0] ctl;
  assign ctl = {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
                id_ex_bubble, ex_me_stall, me_wb_bubble};

  pipe_hazard_ctrl #(
    .FLUSH_CYCLES(2),
    .LDUSE_CYCLES(1),
    .MEM_TIMEOUT (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_rs1_addr   (id_rs1_addr),
    .id_rs2_addr   (id_rs2_addr),
    .id_use_rs1    (id_use_rs1),
    .id_use_rs2    (id_use_rs2),
    .ex_mem_read   (ex_mem_read),
    .ex_rd_addr    (ex_rd_addr),
    .redirect_valid(redirect_valid),
    .me_req        (me_req),
    .me_ready      (me_ready),
    .pc_stall      (pc_stall),
    .if_id_stall   (if_id_stall),
    .if_id_flush   (if_id_flush),
    .id_ex_stall   (id_ex_stall),
    .id_ex_bubble  (id_ex_bubble),
    .ex_me_stall   (ex_me_stall),
    .me_wb_bubble  (me_wb_bubble),
    .state_o       (state_o),
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    .perf_stall_cyc(perf_stall_cyc),
    .perf_flush_cnt(perf_flush_cnt),
`endif
    .timeout_err   (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in;
    id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; ex_rd_addr = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0;
    redirect_valid = 1'b0; me_req = 1'b0; me_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    clr_in();
    #2;
    chk("reset_ctl", 32'(ctl), 32'(C_NONE));
    chk("reset_state", 32'(state_o), 32'd0);
    chk("reset_err", 32'(timeout_err), 32'd0);
    tick(); tick();
    rst_n = 1'b1;

    // Load-use on rs1: one bubble cycle
    tick();
    ex_mem_read = 1'b1; ex_rd_addr = 5'd5; id_use_rs1 = 1'b1; id_rs1_addr = 5'd5;
    #1 chk("ldu_rs1_ctl", 32'(ctl), 32'(C_LDU));
    chk("ldu_rs1_state", 32'(state_o), 32'd0);
    tick(); clr_in();
    #1 chk("ldu_after_ctl", 32'(ctl), 32'(C_NONE));
    chk("ldu_after_state", 32'(state_o), 32'd0);

    // Load-use on rs2, and non-use / x0 cases
    ex_mem_read = 1'b1; ex_rd_addr = 5'd7; id_use_rs2 = 1'b1; id_rs2_addr = 5'd7;
    #1 chk("ldu_rs2_ctl", 32'(ctl), 32'(C_LDU));
    id_use_rs2 = 1'b0;
    #1 chk("ldu_rs2_unused_ctl", 32'(ctl), 32'(C_NONE));
    ex_rd_addr = 5'd0; id_rs1_addr = 5'd0; id_use_rs1 = 1'b1;
    #1 chk("ldu_x0_ctl", 32'(ctl), 32'(C_NONE));
    tick(); clr_in();

    // Memory wait: 4 stall cycles, release on the ready cycle
    me_req = 1'b1;
    #1 chk("mw_c1_ctl", 32'(ctl), 32'(C_STALL));
    chk("mw_c1_state", 32'(state_o), 32'd0);
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk($sformatf("mw_c%0d_ctl", i), 32'(ctl), 32'(C_STALL));
      chk($sformatf("mw_c%0d_state", i), 32'(state_o), 32'd2);
    end
    tick(); me_ready = 1'b1;
    #1 chk("mw_ready_ctl", 32'(ctl), 32'(C_NONE));
    chk("mw_ready_state", 32'(state_o), 32'd2);
    tick(); clr_in();
    #1 chk("mw_done_state", 32'(state_o), 32'd0);

    // Redirect with simultaneous load-use: two flush cycles, never pc_stall
    redirect_valid = 1'b1;
    ex_mem_read = 1'b1; ex_rd_addr = 5'd3; id_use_rs1 = 1'b1; id_rs1_addr = 5'd3;
    #1 chk("redir_c1_ctl", 32'(ctl), 32'(C_FLUSH));
    tick(); redirect_valid = 1'b0;
    #1 chk("redir_c2_ctl", 32'(ctl), 32'(C_FLUSH));
    chk("redir_c2_state", 32'(state_o), 32'd3);
    tick(); clr_in();
    #1 chk("redir_done_ctl", 32'(ctl), 32'(C_NONE));
    chk("redir_done_state", 32'(state_o), 32'd0);

    // Redirect re-presented inside REDIR restarts the count
    redirect_valid = 1'b1;
    tick();
    #1 chk("redir_rst_c2_ctl", 32'(ctl), 32'(C_FLUSH));
    tick(); redirect_valid = 1'b0;
    #1 chk("redir_rst_c3_ctl", 32'(ctl), 32'(C_FLUSH));
    chk("redir_rst_c3_state", 32'(state_o), 32'd3);
    tick();
    chk("redir_rst_done_ctl", 32'(ctl), 32'(C_NONE));

    // Memory wait beats a simultaneous redirect; redirect honoured afterwards
    me_req = 1'b1; redirect_valid = 1'b1;
    #1 chk("prio_c1_ctl", 32'(ctl), 32'(C_STALL));
    tick();
    chk("prio_c2_ctl", 32'(ctl), 32'(C_STALL));
    chk("prio_c2_state", 32'(state_o), 32'd2);
    me_ready = 1'b1;
    #1 chk("prio_ready_ctl", 32'(ctl), 32'(C_NONE));
    tick(); me_req = 1'b0; me_ready = 1'b0;
    #1 chk("prio_redir_ctl", 32'(ctl), 32'(C_FLUSH));
    chk("prio_redir_state", 32'(state_o), 32'd0);
    tick(); redirect_valid = 1'b0;

    // Memory wait arriving mid-REDIR discards the flush count
    me_req = 1'b1;
    #1 chk("redir_mw_ctl", 32'(ctl), 32'(C_STALL));
    chk("redir_mw_state", 32'(state_o), 32'd3);
    tick();
    chk("redir_mw_next_state", 32'(state_o), 32'd2);
    me_ready = 1'b1;
    tick(); clr_in();

    // Timeout: 8 stall cycles then abort with sticky flag
    me_req = 1'b1;
    #1 chk("to_c1_ctl", 32'(ctl), 32'(C_STALL));
    for (int i = 2; i <= 8; i++) begin
      tick();
      chk($sformatf("to_c%0d_ctl", i), 32'(ctl), 32'(C_STALL));
      chk($sformatf("to_c%0d_err", i), 32'(timeout_err), 32'd0);
    end
    tick();
    chk("to_abort_state", 32'(state_o), 32'd0);
    chk("to_abort_err", 32'(timeout_err), 32'd1);
    me_req = 1'b0;
    #1 chk("to_abort_ctl", 32'(ctl), 32'(C_NONE));
    tick(); tick();
    chk("to_sticky_err", 32'(timeout_err), 32'd1);

    // Async reset in the middle of a memory wait
    me_req = 1'b1;
    tick(); tick();
    chk("ar_pre_state", 32'(state_o), 32'd2);
    #2 rst_n = 1'b0;
    #1 chk("ar_ctl", 32'(ctl), 32'(C_NONE));
    chk("ar_state", 32'(state_o), 32'd0);
    chk("ar_err", 32'(timeout_err), 32'd0);
    clr_in();
    tick();
    rst_n = 1'b1;
    tick();
    chk("ar_post_state", 32'(state_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
